buffer_64_to_512: RTL

- Width-up converter and line FIFO, the write-side counterpart of the 512-to-64 read buffer.
- Accepts 64-bit words one per cycle and packs each group of 8 consecutive words into one 512-bit line.
- Queues complete lines in a small FIFO for a 512-bit consumer.
- Sits between the 64-bit host/stream interface and the 512-bit AES datapath/memory side.

---
 rtl/buffer_64_to_512_if.sv | 22 ++
 rtl/buffer_64_to_512.sv | 93 +++++++++
 2 files changed

// File: rtl/buffer_64_to_512_if.sv
// rtl/buffer_64_to_512_if.sv - word-in / line-out bus bundle for the 64-to-512 buffer
interface buffer_64_to_512_if;
    logic         clr;
    logic [63:0]  data_in;
    logic         wr_enable;
    logic [511:0] data_out;
    logic         rd_enable;
    logic         full;
    logic         empty;
    logic         full_n;
    logic [2:0]   word_cnt;

    modport master (
        output clr, data_in, wr_enable, rd_enable,
        input  data_out, full, empty, full_n, word_cnt
    );

    modport slave (
        input  clr, data_in, wr_enable, rd_enable,
        output data_out, full, empty, full_n, word_cnt
    );
endinterface

// File: rtl/buffer_64_to_512.sv
// rtl/buffer_64_to_512.sv - packs 64-bit words into 512-bit lines queued in a small FIFO
module buffer_64_to_512 #(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    buffer_64_to_512_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   LINES_MAX = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LINE_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    // Line storage carries no reset; visibility is governed purely by line_cnt.
    logic [511:0]  mem_q [DEPTH];

    logic [AW-1:0] wr_line_q, wr_line_d;
    logic [AW-1:0] rd_line_q, rd_line_d;
    logic [2:0]    word_cnt_q, word_cnt_d;
    logic [AW:0]   line_cnt_q, line_cnt_d;

    logic full, empty;
    logic wr_acc, rd_acc, line_done;

    assign full  = (line_cnt_q == LINES_MAX);
    assign empty = (line_cnt_q == '0);

    // clr wins over both strobes; full/empty are the values sampled this cycle (no bypass).
    assign wr_acc    = bus.wr_enable && !full && !bus.clr;
    assign rd_acc    = bus.rd_enable && !empty && !bus.clr;
    assign line_done = wr_acc && (word_cnt_q == 3'd7);

    // Next-state for pointers and counters.
    always_comb begin
        wr_line_d  = wr_line_q;
        rd_line_d  = rd_line_q;
        word_cnt_d = word_cnt_q;
        line_cnt_d = line_cnt_q;
        if (bus.clr) begin
            wr_line_d  = '0;
            rd_line_d  = '0;
            word_cnt_d = '0;
            line_cnt_d = '0;
        end else begin
            if (wr_acc) begin
                word_cnt_d = word_cnt_q + 3'd1;
            end
            if (line_done) begin
                wr_line_d = wr_line_q + PTR_ONE;
            end
            if (rd_acc) begin
                rd_line_d = rd_line_q + PTR_ONE;
            end
            case ({line_done, rd_acc})
                2'b10:   line_cnt_d = line_cnt_q + LINE_ONE;
                2'b01:   line_cnt_d = line_cnt_q - LINE_ONE;
                default: line_cnt_d = line_cnt_q;
            endcase
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_line_q  <= '0;
            rd_line_q  <= '0;
            word_cnt_q <= '0;
            line_cnt_q <= '0;
        end else begin
            wr_line_q  <= wr_line_d;
            rd_line_q  <= rd_line_d;
            word_cnt_q <= word_cnt_d;
            line_cnt_q <= line_cnt_d;
        end
    end

    // Drop each accepted word into its 64-bit slot of the line being filled.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_line_q][{word_cnt_q, 6'd0} +: 64] <= bus.data_in;
        end
    end

    // Show-ahead head line; a partial or absent line reads as zero.
    always_comb begin
        bus.data_out = empty ? 512'd0 : mem_q[rd_line_q];
    end

    assign bus.full     = full;
    assign bus.full_n   = ~full;
    assign bus.empty    = empty;
    assign bus.word_cnt = word_cnt_q;
endmodule
